// File: rtl/x_input_conditioner_pkg.sv
// Shared types and defaults for the x input conditioner.
// Debounce FSM encoding and default parameter values.
package x_input_conditioner_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    CHK_HIGH    = 2'b01,
    HIGH_STABLE = 2'b10,
    CHK_LOW     = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_GLITCH_W        = 8;

endpackage

// File: rtl/x_input_conditioner_sync_chain.sv
// Reusable multi-flop synchroniser.
// Plain shift chain, async active-low reset to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ff <= '0;
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/x_input_conditioner.sv
// Synchronise, debounce and edge-detect the raw x input.
// Counts aborted debounce attempts as glitches.
module x_input_conditioner
  import x_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEF_GLITCH_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                x_raw,
  output logic                x,
  output logic                x_rise,
  output logic                x_fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW:0] LAST = (CW+1)'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam bit FAST = (DEBOUNCE_CYCLES == 1);

  logic s;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW:0] cnt_inc;
  logic x_n, rise_n, fall_n;
  logic [GLITCH_W-1:0] glitch_n, glitch_inc;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (x_raw),
    .q  (s)
  );

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign glitch_inc = (&glitch_cnt) ? glitch_cnt
                                    : glitch_cnt + GLITCH_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= LOW_STABLE;
      cnt        <= '0;
      x          <= 1'b0;
      x_rise     <= 1'b0;
      x_fall     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      x          <= x_n;
      x_rise     <= rise_n;
      x_fall     <= fall_n;
      glitch_cnt <= glitch_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    x_n      = x;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    glitch_n = glitch_cnt;
    unique case (state)
      LOW_STABLE: begin
        if (s && FAST) begin
          state_n = HIGH_STABLE;
          x_n     = 1'b1;
          rise_n  = 1'b1;
        end else if (s) begin
          state_n = CHK_HIGH;
          cnt_n   = ONE;
        end
      end
      CHK_HIGH: begin
        if (s && cnt_inc == LAST) begin
          state_n = HIGH_STABLE;
          x_n     = 1'b1;
          rise_n  = 1'b1;
          cnt_n   = '0;
        end else if (s) begin
          cnt_n = cnt_inc[CW-1:0];
        end else begin
          state_n  = LOW_STABLE;
          cnt_n    = '0;
          glitch_n = glitch_inc;
        end
      end
      HIGH_STABLE: begin
        if (!s && FAST) begin
          state_n = LOW_STABLE;
          x_n     = 1'b0;
          fall_n  = 1'b1;
        end else if (!s) begin
          state_n = CHK_LOW;
          cnt_n   = ONE;
        end
      end
      CHK_LOW: begin
        if (!s && cnt_inc == LAST) begin
          state_n = LOW_STABLE;
          x_n     = 1'b0;
          fall_n  = 1'b1;
          cnt_n   = '0;
        end else if (!s) begin
          cnt_n = cnt_inc[CW-1:0];
        end else begin
          state_n  = HIGH_STABLE;
          cnt_n    = '0;
          glitch_n = glitch_inc;
        end
      end
      default: begin
        state_n = LOW_STABLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
